// File: rtl/draw_cred_ball_pkg.sv
// Shared VGA constants and the timing-bus payload used by the credits ball overlay.
package draw_cred_ball_pkg;

  localparam int unsigned HC_W   = 11;
  localparam int unsigned VC_W   = 11;
  localparam int unsigned POS_W  = 12;
  localparam int unsigned RGB_W  = 12;
  localparam int unsigned CALC_W = 13;
  localparam int unsigned D2_W   = 15;

  localparam int unsigned SCREEN_W = 1024;
  localparam int unsigned SCREEN_H = 768;

  localparam int unsigned BALL_DIAM  = 128;
  localparam int unsigned BALL_R2    = 4096;
  localparam int unsigned OUTLINE_D2 = 3600;

  // Ball parks near the top centre until the first frame boundary.
  localparam int unsigned XLAT_RST = SCREEN_W / 2 - 1;
  localparam int unsigned YLAT_RST = 40;

  localparam logic [RGB_W-1:0] COLOR_WHITE = 12'hFFF;
  localparam logic [RGB_W-1:0] COLOR_RED   = 12'hF00;

  typedef struct packed {
    logic [HC_W-1:0] hcount;
    logic [VC_W-1:0] vcount;
    logic            hsync;
    logic            vsync;
    logic            hblnk;
    logic            vblnk;
  } vga_timing_t;

endpackage

// File: rtl/draw_cred_ball_vga_delay.sv
// N-stage register delay for the VGA timing bus.
module vga_delay
  import draw_cred_ball_pkg::*;
#(
  parameter int unsigned N = 2
) (
  input  logic        pclk,
  input  logic        rst,
  input  vga_timing_t bus_i,
  output vga_timing_t bus_o
);

  vga_timing_t stage_q [N];

  always_ff @(posedge pclk) begin
    if (rst) begin
      for (int i = 0; i < int'(N); i++) stage_q[i] <= '0;
    end else begin
      stage_q[0] <= bus_i;
      for (int i = 1; i < int'(N); i++) stage_q[i] <= stage_q[i-1];
    end
  end

  assign bus_o = stage_q[N-1];

endmodule

// File: rtl/draw_cred_ball.sv
// Credits ball overlay: draws a disk over the background with 2-cycle latency.
// Optional ring colour for the outer band when BALL_OUTLINE_EN is defined.
module draw_cred_ball
  import draw_cred_ball_pkg::*;
#(
  parameter int unsigned       BALL_DIAMETER = BALL_DIAM,
  parameter logic [RGB_W-1:0]  BALL_COLOR    = COLOR_WHITE,
  parameter logic [RGB_W-1:0]  OUTLINE_COLOR = COLOR_RED
) (
  input  logic              pclk,
  input  logic              rst,
  input  logic [POS_W-1:0]  xpos,
  input  logic [POS_W-1:0]  ypos,
  input  logic [HC_W-1:0]   hcount_in,
  input  logic [VC_W-1:0]   vcount_in,
  input  logic              hsync_in,
  input  logic              vsync_in,
  input  logic              hblnk_in,
  input  logic              vblnk_in,
  input  logic [RGB_W-1:0]  rgb_in,
  output logic [HC_W-1:0]   hcount_out,
  output logic [VC_W-1:0]   vcount_out,
  output logic              hsync_out,
  output logic              vsync_out,
  output logic              hblnk_out,
  output logic              vblnk_out,
  output logic [RGB_W-1:0]  rgb_out
);

  localparam int unsigned HALF  = BALL_DIAMETER / 2;
  localparam int unsigned MAG_W = $clog2(HALF) + 1;

  vga_timing_t tim_in;
  vga_timing_t tim_out;

  assign tim_in = '{hcount: hcount_in, vcount: vcount_in, hsync: hsync_in,
                    vsync: vsync_in, hblnk: hblnk_in, vblnk: vblnk_in};

  vga_delay #(.N(2)) u_vga_delay (
    .pclk  (pclk),
    .rst   (rst),
    .bus_i (tim_in),
    .bus_o (tim_out)
  );

  assign hcount_out = tim_out.hcount;
  assign vcount_out = tim_out.vcount;
  assign hsync_out  = tim_out.hsync;
  assign vsync_out  = tim_out.vsync;
  assign hblnk_out  = tim_out.hblnk;
  assign vblnk_out  = tim_out.vblnk;

  logic              vblnk_prev_q, vblnk_prev_d;
  logic [POS_W-1:0]  xlat_q, xlat_d;
  logic [POS_W-1:0]  ylat_q, ylat_d;
  logic [CALC_W-1:0] dx_q, dx_d;
  logic [CALC_W-1:0] dy_q, dy_d;
  logic              box_q, box_d;
  logic              blank_s1_q, blank_s1_d;
  logic [RGB_W-1:0]  rgb_s1_q, rgb_s1_d;
  logic [RGB_W-1:0]  rgb_q, rgb_d;

  logic [CALC_W-1:0] hrel, vrel;
  logic [CALC_W-1:0] adx, ady;
  logic [D2_W-1:0]   d2;
  logic              unused_bits;

  // Stage 1: frame-boundary position latch and offsets from the box corner.
  // A negative offset wraps to a large unsigned value, so one compare bounds both sides.
  always_comb begin
    vblnk_prev_d = vblnk_in;
    xlat_d       = xlat_q;
    ylat_d       = ylat_q;
    if (vblnk_in && !vblnk_prev_q) begin
      xlat_d = xpos;
      ylat_d = ypos;
    end
    hrel       = CALC_W'(hcount_in) - CALC_W'(xlat_q);
    vrel       = CALC_W'(vcount_in) - CALC_W'(ylat_q);
    dx_d       = hrel - CALC_W'(HALF);
    dy_d       = vrel - CALC_W'(HALF);
    box_d      = (hrel < CALC_W'(BALL_DIAMETER)) && (vrel < CALC_W'(BALL_DIAMETER));
    blank_s1_d = hblnk_in | vblnk_in;
    rgb_s1_d   = rgb_in;
  end

  // Stage 2: radius test; inside the box |dx|,|dy| <= HALF so only MAG_W bits matter.
  always_comb begin
    adx   = dx_q[CALC_W-1] ? (CALC_W'(0) - dx_q) : dx_q;
    ady   = dy_q[CALC_W-1] ? (CALC_W'(0) - dy_q) : dy_q;
    d2    = D2_W'(adx[MAG_W-1:0]) * D2_W'(adx[MAG_W-1:0])
          + D2_W'(ady[MAG_W-1:0]) * D2_W'(ady[MAG_W-1:0]);
    rgb_d = rgb_s1_q;
    if (box_q && !blank_s1_q && (d2 < D2_W'(BALL_R2))) begin
`ifdef BALL_OUTLINE_EN
      rgb_d = (d2 >= D2_W'(OUTLINE_D2)) ? OUTLINE_COLOR : BALL_COLOR;
`else
      rgb_d = BALL_COLOR;
`endif
    end
  end

`ifdef BALL_OUTLINE_EN
  assign unused_bits = ^{adx[CALC_W-1:MAG_W], ady[CALC_W-1:MAG_W]};
`else
  assign unused_bits = ^{adx[CALC_W-1:MAG_W], ady[CALC_W-1:MAG_W], OUTLINE_COLOR};
`endif

  always_ff @(posedge pclk) begin
    if (rst) begin
      vblnk_prev_q <= 1'b0;
      xlat_q       <= POS_W'(XLAT_RST);
      ylat_q       <= POS_W'(YLAT_RST);
      dx_q         <= '0;
      dy_q         <= '0;
      box_q        <= 1'b0;
      blank_s1_q   <= 1'b0;
      rgb_s1_q     <= '0;
      rgb_q        <= '0;
    end else begin
      vblnk_prev_q <= vblnk_prev_d;
      xlat_q       <= xlat_d;
      ylat_q       <= ylat_d;
      dx_q         <= dx_d;
      dy_q         <= dy_d;
      box_q        <= box_d;
      blank_s1_q   <= blank_s1_d;
      rgb_s1_q     <= rgb_s1_d;
      rgb_q        <= rgb_d;
    end
  end

  assign rgb_out = rgb_q;

endmodule
